// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : operation encodings as presented on the op port
//   md_state_e : control FSM states (IDLE -> RUN -> FIX -> IDLE)
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One iteration of the shared multiply/divide datapath, purely combinational.
// The accumulator is 2*WL+1 bits: the upper WL+1 bits hold the partial
// product (multiply) or the partial remainder (divide), the lower WL bits
// hold the multiplier being consumed or the dividend/quotient.
//   i_acc    : current accumulator
//   i_opnd   : multiplicand (multiply) or divisor (divide), magnitude
//   i_is_div : 1 = restoring divide step, 0 = shift-add multiply step
//   o_acc    : accumulator after this iteration
module muldiv_step #(
    parameter int WL = 32
) (
    input  logic [2*WL:0] i_acc,
    input  logic [WL-1:0] i_opnd,
    input  logic          i_is_div,
    output logic [2*WL:0] o_acc
);

    logic [WL:0]   w_sum;
    logic [2*WL:0] w_shl;
    logic [WL:0]   w_diff;
    logic          w_fits;
    logic [2*WL:0] w_mul_nxt;
    logic [2*WL:0] w_div_nxt;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // right. The top bit is always 0 before the add, so the WL+1-bit sum
    // cannot overflow.
    assign w_sum     = i_acc[2*WL:WL] + (i_acc[0] ? {1'b0, i_opnd} : {(WL+1){1'b0}});
    assign w_mul_nxt = {1'b0, w_sum, i_acc[WL-1:1]};

    // Divide: shift left, trial-subtract the divisor from the WL+1-bit
    // remainder, keep the difference and set the quotient bit if it fits.
    assign w_shl     = {i_acc[2*WL-1:0], 1'b0};
    assign w_fits    = (w_shl[2*WL:WL] >= {1'b0, i_opnd});
    assign w_diff    = w_shl[2*WL:WL] - {1'b0, i_opnd};
    assign w_div_nxt = w_fits ? {w_diff, w_shl[WL-1:1], 1'b1} : w_shl;

    assign o_acc = i_is_div ? w_div_nxt : w_mul_nxt;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are captured as magnitudes at start, iterated WL times through
// muldiv_step, then sign-corrected and written to HI/LO in one FIX cycle.
//   CLK          : clock
//   RST          : synchronous, active-high reset
//   start, op    : launch operation op on x, y (ignored while busy)
//   x, y         : rs / rt operands
//   hi_we, lo_we : MTHI / MTLO write strobes with wdata (ignored while busy)
//   busy         : operation in progress (RUN or FIX)
//   done         : one-cycle pulse when HI/LO were updated by an operation
//   hi, lo       : HI / LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WL = 32,
    parameter int CW = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [WL-1:0] x,
    input  logic [WL-1:0] y,
    input  logic          hi_we,
    input  logic          lo_we,
    input  logic [WL-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [WL-1:0] hi,
    output logic [WL-1:0] lo
);

    md_state_e       r_state;
    md_state_e       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [WL-1:0]   r_hi;
    logic [WL-1:0]   r_lo;

    logic [2*WL:0]   r_acc;
    logic [WL-1:0]   r_opnd;
    logic            r_is_div;
    logic            r_neg_res;
    logic            r_neg_rem;

    md_op_e          w_op;
    logic            w_signed;
    logic            w_is_div;
    logic            w_x_neg;
    logic            w_y_neg;
    logic [WL-1:0]   w_x_mag;
    logic [WL-1:0]   w_y_mag;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [2*WL:0]   w_acc_nxt;
    logic [2*WL-1:0] w_prod;
    logic [2*WL-1:0] w_prod_fix;
    logic [WL-1:0]   w_quo_fix;
    logic [WL-1:0]   w_rem_fix;

    // ---------------- operand decode and magnitude capture ----------------
    assign w_op     = md_op_e'(op);
    assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    assign w_is_div = (w_op == MD_DIV)  || (w_op == MD_DIVU);
    assign w_x_neg  = w_signed & x[WL-1];
    assign w_y_neg  = w_signed & y[WL-1];
    assign w_x_mag  = w_x_neg ? (~x + 1'b1) : x;
    assign w_y_mag  = w_y_neg ? (~y + 1'b1) : y;

    muldiv_step #(.WL(WL)) u_step (
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .i_is_div (r_is_div),
        .o_acc    (w_acc_nxt)
    );

    // ---------------- FIX sign correction ----------------
    assign w_prod     = r_acc[2*WL-1:0];
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = r_neg_res ? (~r_acc[WL-1:0] + 1'b1) : r_acc[WL-1:0];
    assign w_rem_fix  = r_neg_rem ? (~r_acc[2*WL-1:WL] + 1'b1) : r_acc[2*WL-1:WL];

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered below) ----------------
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_FIX);
    end

    // ---------------- FSM: state register and architectural state ----------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            case (r_state)
                S_IDLE: if (start) r_cnt <= CW'(WL);
                S_RUN:  r_cnt <= r_cnt - CW'(1);
                default: ;
            endcase
            // MTHI/MTLO only while idle; FIX (busy) is the only other writer.
            if (!r_busy) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
            if (r_state == S_FIX) begin
                r_hi <= r_is_div ? w_rem_fix : w_prod_fix[2*WL-1:WL];
                r_lo <= r_is_div ? w_quo_fix : w_prod_fix[WL-1:0];
            end
        end
    end

    // ---------------- datapath registers ----------------
    // NOTE: no reset here; these are always loaded at start before being used.
    always_ff @(posedge CLK) begin
        if (r_state == S_IDLE && start) begin
            r_is_div  <= w_is_div;
            // Divide by zero keeps the quotient at all ones; the remainder
            // then sign-corrects back to x exactly.
            r_neg_res <= (w_x_neg ^ w_y_neg) && !(w_is_div && (y == '0));
            r_neg_rem <= w_x_neg;
            r_opnd    <= w_is_div ? w_y_mag : w_x_mag;
            r_acc     <= {{(WL+1){1'b0}}, (w_is_div ? w_x_mag : w_y_mag)};
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

    localparam int WL = 32;
    localparam int CW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [1:0]    op;
    logic [WL-1:0] x, y;
    logic          hi_we, lo_we;
    logic [WL-1:0] wdata;
    logic          busy, done;
    logic [WL-1:0] hi, lo;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WL(WL), .CW(CW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .op    (op),
        .x     (x),
        .y     (y),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation at edge E0 and follow it to completion.
    // inj_cyc != 0: during that cycle assert start(DIV) and lo_we, which must be ignored.
    // hi_wr: assert hi_we with start at E0; the MTHI lands, then FIX overwrites it.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [WL-1:0] a, input logic [WL-1:0] b,
                          input logic [WL-1:0] exp_hi, input logic [WL-1:0] exp_lo,
                          input int inj_cyc, input logic hi_wr);
        int busy_bad;
        @(negedge CLK);
        op = o; x = a; y = b; start = 1'b1;
        hi_we = hi_wr; wdata = 32'hDEAD_BEEF;
        @(posedge CLK); #1;                       // cycle 1
        start = 1'b0; hi_we = 1'b0;
        x = ~a; y = ~b;                           // operands must already be captured
        if (hi_wr) check({tag, ".mthi_at_start"}, 64'(hi), 64'hDEAD_BEEF);
        busy_bad = 0;
        for (int c = 1; c <= WL + 1; c++) begin
            if (c > 1) begin
                @(posedge CLK); #1;
            end
            if (!busy || done) busy_bad++;
            if (inj_cyc != 0 && c == inj_cyc) begin
                start = 1'b1; op = 2'b10; lo_we = 1'b1; wdata = 32'h0000_1234;
            end else if (inj_cyc != 0 && c == inj_cyc + 1) begin
                start = 1'b0; lo_we = 1'b0;
            end
        end
        check({tag, ".busy_window"}, 64'(busy_bad), 64'd0);
        @(posedge CLK); #1;                       // cycle WL+2
        check({tag, ".done"},      64'(done), 64'd1);
        check({tag, ".busy_done"}, 64'(busy), 64'd0);
        check({tag, ".hi"},        64'(hi),   64'(exp_hi));
        check({tag, ".lo"},        64'(lo),   64'(exp_lo));
        @(posedge CLK); #1;
        check({tag, ".done_pulse"}, 64'({done, busy}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; start = 1'b0; op = 2'b00; x = '0; y = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hilo", {hi, lo}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("mult_7x-3",  2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
        run_op("multu_max",  2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
        run_op("div_-7/2",   2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("div_7/-2",   2'b10, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("div_min/-1", 2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 1'b0);
        run_op("divu_100/7", 2'b11, 32'd100,        32'd7,         32'd2,         32'd14,        0, 1'b0);
        run_op("divu_by0",   2'b11, 32'h0000_0064,  32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_-5by0",  2'b10, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("multu_busy_ign", 2'b01, 32'd3,      32'd5,         32'd0,         32'd15,        10, 1'b0);

        // MTLO while idle takes effect at the next edge; HI untouched.
        @(negedge CLK);
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge CLK); #1;
        lo_we = 1'b0;
        check("mtlo_idle.lo", 64'(lo), 64'h1234);
        check("mtlo_idle.hi", 64'(hi), 64'd0);

        // Reset in the middle of a DIV abandons it with no partial write.
        @(negedge CLK);
        op = 2'b10; x = 32'd1000; y = 32'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (11) @(posedge CLK);
        #1;                                        // cycle 12
        check("rst_mid.busy_before", 64'(busy), 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        check("rst_mid.hilo", {hi, lo}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Fresh MULT after reset, with MTHI at the same start edge.
        run_op("mult_2x2", 2'b00, 32'd2, 32'd2, 32'd0, 32'd4, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
